// File: rtl/seq_multiplier_taint_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier_taint_if
// Brief    : Start/done handshake, operands, result and shadow-taint bundle
//            for the taint-tracking sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_multiplier_taint_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 start_t;
    logic                 signed_mode;
    logic                 signed_mode_t;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplicand_t;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     multiplier_t;
    logic                 busy;
    logic                 done;
    logic                 done_t;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   product_t;

    modport master (
        output start, start_t, signed_mode, signed_mode_t,
        output multiplicand, multiplicand_t, multiplier, multiplier_t,
        input  busy, done, done_t, product, product_t
    );

    modport slave (
        input  start, start_t, signed_mode, signed_mode_t,
        input  multiplicand, multiplicand_t, multiplier, multiplier_t,
        output busy, done, done_t, product, product_t
    );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier_taint.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier_taint
// Brief    : Shift-add multiplier (unsigned / two's-complement) with
//            conservative bit-level taint propagation through the datapath.
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier_taint #(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    seq_multiplier_taint_if.slave   bus
);
    localparam int                c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_a_t;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_b_t;
    logic                 r_signed;
    logic                 r_ctl_t;
    logic [2*WIDTH:0]     r_acc;
    logic [2*WIDTH:0]     r_acc_t;
    logic [c_CW-1:0]      r_count;
    logic [2*WIDTH-1:0]   r_product;
    logic [2*WIDTH-1:0]   r_product_t;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_bit;
    logic                 w_bit_t;
    logic [WIDTH:0]       w_ext_a;
    logic [WIDTH:0]       w_ext_at;
    logic [WIDTH:0]       w_upper;
    logic [WIDTH:0]       w_taint_or;
    logic [WIDTH:0]       w_prefix;
    logic [WIDTH:0]       w_upper_t;
    logic [2*WIDTH:0]     w_acc_mod;
    logic [2*WIDTH:0]     w_acc_next;
    logic [2*WIDTH:0]     w_acct_mod;
    logic [2*WIDTH:0]     w_acct_next;

    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_RUN) && (r_count == c_LAST);

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  w_state_next = bus.start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // One iteration of the datapath and its taint shadow
    // ------------------------------------------------------------------------
    always_comb begin
        w_ext_a  = {r_signed & r_a[WIDTH-1],   r_a};
        w_ext_at = {r_signed & r_a_t[WIDTH-1], r_a_t};
        w_bit    = r_b[r_count];
        w_bit_t  = r_b_t[r_count];

        // The final signed step carries negative weight, hence the subtract.
        w_upper = r_acc[2*WIDTH:WIDTH];
        if (w_bit) begin
            if (r_signed && (r_count == c_LAST)) begin
                w_upper = r_acc[2*WIDTH:WIDTH] - w_ext_a;
            end else begin
                w_upper = r_acc[2*WIDTH:WIDTH] + w_ext_a;
            end
        end
        w_acc_mod = {w_upper, r_acc[WIDTH-1:0]};
        if (r_signed) begin
            w_acc_next = $signed(w_acc_mod) >>> 1;
        end else begin
            w_acc_next = w_acc_mod >> 1;
        end

        // Any tainted addend bit may influence every carry above it.
        w_taint_or  = r_acc_t[2*WIDTH:WIDTH] | w_ext_at;
        w_prefix    = '0;
        w_prefix[0] = w_taint_or[0];
        for (int i = 1; i <= WIDTH; i++) begin
            w_prefix[i] = w_prefix[i-1] | w_taint_or[i];
        end

        w_upper_t = r_acc_t[2*WIDTH:WIDTH];
        if (w_bit_t) begin
            w_upper_t = '1;
        end else if (w_bit) begin
            w_upper_t = w_prefix;
        end
        w_acct_mod = {w_upper_t, r_acc_t[WIDTH-1:0]};
        if (r_signed) begin
            w_acct_next = $signed(w_acct_mod) >>> 1;
        end else begin
            w_acct_next = w_acct_mod >> 1;
        end
    end

    // ------------------------------------------------------------------------
    // Operand, accumulator and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_a_t       <= '0;
            r_b         <= '0;
            r_b_t       <= '0;
            r_signed    <= 1'b0;
            r_ctl_t     <= 1'b0;
            r_acc       <= '0;
            r_acc_t     <= '0;
            r_count     <= '0;
            r_product   <= '0;
            r_product_t <= '0;
        end else if (w_accept) begin
            r_a      <= bus.multiplicand;
            r_a_t    <= bus.multiplicand_t;
            r_b      <= bus.multiplier;
            r_b_t    <= bus.multiplier_t;
            r_signed <= bus.signed_mode;
            r_ctl_t  <= bus.start_t | bus.signed_mode_t;
            r_acc    <= '0;
            r_acc_t  <= '0;
            r_count  <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_next;
            r_acc_t <= w_acct_next;
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_product   <= w_acc_next[2*WIDTH-1:0];
                r_product_t <= r_ctl_t ? '1 : w_acct_next[2*WIDTH-1:0];
            end
        end
    end

    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.done_t    = (r_state == S_DONE) && r_ctl_t;
    assign bus.product   = r_product;
    assign bus.product_t = r_product_t;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_taint.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier_taint
// Brief    : Self-checking bench: directed vectors, taint cases, random ops
//            against an arithmetic reference, reset abort and back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier_taint;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seq_multiplier_taint_if #(.WIDTH(W)) bus ();
    seq_multiplier_taint #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference product from plain integer multiplication.
    function automatic logic [2*W-1:0] model_p(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sm);
        longint r;
        longint sa;
        longint sb;
        if (sm) begin
            sa = $signed(a);
            sb = $signed(b);
            r  = sa * sb;
        end else begin
            r = longint'(a) * longint'(b);
        end
        return r[2*W-1:0];
    endfunction

    // Reference taint: per multiplier bit, either saturate the top half or
    // taint everything from the lowest contributing tainted bit upward.
    function automatic logic [2*W-1:0] model_t(input logic [W-1:0] at, input logic [W-1:0] b,
                                               input logic [W-1:0] bt, input logic sm,
                                               input logic ctl);
        logic [2*W:0] t;
        logic [W:0]   ext;
        logic [W:0]   up;
        logic [W:0]   u;
        int           low;
        if (ctl) return '1;
        t   = '0;
        ext = {sm & at[W-1], at};
        for (int i = 0; i < W; i++) begin
            up = t[2*W:W];
            if (bt[i]) begin
                up = '1;
            end else if (b[i]) begin
                u   = up | ext;
                low = -1;
                for (int k = W; k >= 0; k--) if (u[k]) low = k;
                up  = (low < 0) ? '0 : ({(W+1){1'b1}} << low);
            end
            t[2*W:W] = up;
            t = {sm & t[2*W], t[2*W:1]};
        end
        return t[2*W-1:0];
    endfunction

    task automatic drive_idle();
        bus.start          = 1'b0;
        bus.start_t        = 1'b0;
        bus.signed_mode    = 1'b0;
        bus.signed_mode_t  = 1'b0;
        bus.multiplicand   = '0;
        bus.multiplicand_t = '0;
        bus.multiplier     = '0;
        bus.multiplier_t   = '0;
    endtask

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                            input logic [W-1:0] at, input logic [W-1:0] bt,
                            input logic st, input logic smt);
        bus.start          = 1'b1;
        bus.start_t        = st;
        bus.signed_mode    = sm;
        bus.signed_mode_t  = smt;
        bus.multiplicand   = a;
        bus.multiplicand_t = at;
        bus.multiplier     = b;
        bus.multiplier_t   = bt;
    endtask

    // Issues one operation and returns what was observed at the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          input logic [W-1:0] at, input logic [W-1:0] bt,
                          input logic st, input logic smt,
                          output logic seen, output int busy_cyc,
                          output logic [2*W-1:0] p, output logic [2*W-1:0] pt,
                          output logic dt);
        @(negedge clk);
        drive_op(a, b, sm, at, bt, st, smt);
        @(negedge clk);
        drive_idle();
        seen     = 1'b0;
        busy_cyc = 0;
        for (int c = 0; c < 4*W; c++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cyc++;
            @(negedge clk);
        end
        p  = bus.product;
        pt = bus.product_t;
        dt = bus.done_t;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_tests++; if (bus.done_t !== 1'b0) begin n_fail++; $display("FAIL reset_done_t got %b want 0", bus.done_t); end
        n_tests++; if (bus.product !== '0) begin n_fail++; $display("FAIL reset_product got %h want 0", bus.product); end
        n_tests++; if (bus.product_t !== '0) begin n_fail++; $display("FAIL reset_product_t got %h want 0", bus.product_t); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0]   va [4] = '{8'd13, 8'hFD, 8'h80, 8'hFF};
        logic [W-1:0]   vb [4] = '{8'd11, 8'd5,  8'h80, 8'hFF};
        logic           vs [4] = '{1'b0,  1'b1,  1'b1,  1'b0};
        logic [2*W-1:0] ve [4] = '{16'h008F, 16'hFFF1, 16'h4000, 16'hFE01};
        logic seen; int bc; logic [2*W-1:0] p, pt; logic dt;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vs[i], '0, '0, 1'b0, 1'b0, seen, bc, p, pt, dt);
            n_tests++;
            if (!seen || p !== ve[i] || pt !== '0 || dt !== 1'b0 || bc != W) begin
                n_fail++;
                $display("FAIL directed_%0d got done=%b busy=%0d p=%h pt=%h dt=%b want p=%h pt=0 dt=0 busy=%0d",
                         i, seen, bc, p, pt, dt, ve[i], W);
            end
        end
    endtask

    task automatic test_taint();
        logic seen; int bc; logic [2*W-1:0] p, pt; logic dt;
        run_op(8'h5A, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, seen, bc, p, pt, dt);
        n_tests++;
        if (!seen || p !== 16'h0000 || pt !== 16'h0000 || dt !== 1'b0) begin
            n_fail++; $display("FAIL taint_mask got p=%h pt=%h dt=%b want p=0 pt=0 dt=0", p, pt, dt);
        end
        run_op(8'h37, 8'h00, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, seen, bc, p, pt, dt);
        n_tests++;
        if (!seen || pt !== 16'h01FF || dt !== 1'b0) begin
            n_fail++; $display("FAIL taint_ctrl got pt=%h dt=%b want pt=01ff dt=0", pt, dt);
        end
        run_op(8'd2, 8'd3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, seen, bc, p, pt, dt);
        n_tests++;
        if (!seen || p !== 16'h0006 || pt !== 16'hFFFF || dt !== 1'b1) begin
            n_fail++; $display("FAIL taint_mode got p=%h pt=%h dt=%b want p=0006 pt=ffff dt=1", p, pt, dt);
        end
        run_op(8'd9, 8'd9, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, seen, bc, p, pt, dt);
        n_tests++;
        if (!seen || p !== 16'h0051 || pt !== 16'hFFFF || dt !== 1'b1) begin
            n_fail++; $display("FAIL taint_start got p=%h pt=%h dt=%b want p=0051 pt=ffff dt=1", p, pt, dt);
        end
    endtask

    task automatic test_random();
        logic seen; int bc; logic [2*W-1:0] p, pt, ep, ept; logic dt;
        logic [W-1:0] a, b, at, bt; logic sm, st, smt;
        for (int i = 0; i < 40; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            sm  = 1'($urandom);
            at  = ($urandom_range(0, 2) == 0) ? W'($urandom) & W'($urandom) : '0;
            bt  = ($urandom_range(0, 3) == 0) ? (W'(1) << $urandom_range(0, W-1)) : '0;
            st  = ($urandom_range(0, 9) == 0);
            smt = ($urandom_range(0, 9) == 0);
            run_op(a, b, sm, at, bt, st, smt, seen, bc, p, pt, dt);
            ep  = model_p(a, b, sm);
            ept = model_t(at, b, bt, sm, st | smt);
            n_tests++;
            if (!seen || bc != W || p !== ep || pt !== ept || dt !== (st | smt)) begin
                n_fail++;
                $display("FAIL random_%0d a=%h b=%h sm=%b at=%h bt=%h got done=%b busy=%0d p=%h pt=%h dt=%b want p=%h pt=%h dt=%b",
                         i, a, b, sm, at, bt, seen, bc, p, pt, dt, ep, ept, st | smt);
            end
            @(negedge clk);
            n_tests++;
            if (bus.done !== 1'b0) begin n_fail++; $display("FAIL random_pulse_%0d got done=%b want 0", i, bus.done); end
        end
    endtask

    task automatic test_reset_abort();
        logic seen; int bc; logic [2*W-1:0] p, pt; logic dt;
        run_op(8'd13, 8'd11, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, seen, bc, p, pt, dt);
        @(negedge clk);
        drive_op(8'd9, 8'd9, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy got %b want 1", bus.busy); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0 || bus.product_t !== '0) begin
            n_fail++;
            $display("FAIL abort_async got busy=%b done=%b p=%h pt=%h want all 0",
                     bus.busy, bus.done, bus.product, bus.product_t);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic seen; int bc; int pulses;
        pulses = 0;
        @(negedge clk);
        drive_op(8'd7, 8'd7, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        drive_idle();
        seen = 1'b0;
        for (int c = 0; c < 4*W; c++) begin
            if (bus.done === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (seen) pulses++;
        n_tests++;
        if (!seen || bus.product !== 16'h0031) begin
            n_fail++; $display("FAIL b2b_first got done=%b p=%h want p=0031", seen, bus.product);
        end
        drive_op(8'd2, 8'd2, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        drive_idle();
        n_tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.product !== 16'h0031) begin
            n_fail++;
            $display("FAIL b2b_gap got busy=%b done=%b p=%h want busy=1 done=0 p=0031",
                     bus.busy, bus.done, bus.product);
        end
        seen = 1'b0;
        bc   = 0;
        for (int c = 0; c < 4*W; c++) begin
            if (bus.done === 1'b1) begin seen = 1'b1; break; end
            if (bus.busy === 1'b1) bc++;
            @(negedge clk);
        end
        if (seen) pulses++;
        n_tests++;
        if (!seen || bus.product !== 16'h0004 || bc != W || pulses != 2) begin
            n_fail++;
            $display("FAIL b2b_second got done=%b busy=%0d p=%h pulses=%0d want p=0004 busy=%0d pulses=2",
                     seen, bc, bus.product, pulses, W);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_taint();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
